// File: rtl/thermo_pkg.sv
// thermo_pkg: state encoding and default thresholds shared by the thermostat power controller
package thermo_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOL  = 2'd1;
  localparam logic [1:0] S_HEAT  = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;
  localparam int DEF_T_W       = 8;
  localparam int DEF_HEAT_ON   = 15;
  localparam int DEF_HEAT_OFF  = 30;
  localparam int DEF_COOL_ON   = 35;
  localparam int DEF_COOL_OFF  = 25;
  localparam int DEF_STEP      = 5;
  localparam int DEF_ALARM_LO  = -10;
  localparam int DEF_ALARM_HI  = 60;
  localparam int DEF_MIN_DWELL = 8;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter; busy while non-zero, clr overrides load
module dwell_timer #(
  parameter int unsigned N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic busy
);
  logic [7:0] cnt_q, cnt_d;
  assign busy = |cnt_q;
  always_comb cnt_d = clr ? 8'd0 : load ? 8'(N) : busy ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/thermo_power_ctrl.sv
// thermo_power_ctrl: hysteretic heat/cool controller with power levels, dwell and alarm
module thermo_power_ctrl
  import thermo_pkg::*;
#(
  parameter int T_W       = DEF_T_W,
  parameter int HEAT_ON   = DEF_HEAT_ON,
  parameter int HEAT_OFF  = DEF_HEAT_OFF,
  parameter int COOL_ON   = DEF_COOL_ON,
  parameter int COOL_OFF  = DEF_COOL_OFF,
  parameter int STEP      = DEF_STEP,
  parameter int ALARM_LO  = DEF_ALARM_LO,
  parameter int ALARM_HI  = DEF_ALARM_HI,
  parameter int MIN_DWELL = DEF_MIN_DWELL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  t_valid,
  input  logic signed [T_W-1:0] T,
  output logic                  heater,
  output logic                  cooler,
  output logic [1:0]            heat_lvl,
  output logic [1:0]            cool_lvl,
  output logic [1:0]            state,
  output logic                  dwell_busy
);
  localparam logic signed [T_W-1:0] H_ON  = T_W'(HEAT_ON);
  localparam logic signed [T_W-1:0] H_OFF = T_W'(HEAT_OFF);
  localparam logic signed [T_W-1:0] C_ON  = T_W'(COOL_ON);
  localparam logic signed [T_W-1:0] C_OFF = T_W'(COOL_OFF);
  localparam logic signed [T_W-1:0] H_L2  = T_W'(HEAT_ON - STEP);
  localparam logic signed [T_W-1:0] H_L3  = T_W'(HEAT_ON - 2 * STEP);
  localparam logic signed [T_W-1:0] C_L2  = T_W'(COOL_ON + STEP);
  localparam logic signed [T_W-1:0] C_L3  = T_W'(COOL_ON + 2 * STEP);
  localparam logic signed [T_W-1:0] A_LO  = T_W'(ALARM_LO);
  localparam logic signed [T_W-1:0] A_HI  = T_W'(ALARM_HI);
  if (!(HEAT_ON < HEAT_OFF && COOL_OFF < COOL_ON && HEAT_ON < COOL_ON &&
        ALARM_LO < HEAT_ON && COOL_ON < ALARM_HI && MIN_DWELL >= 1 && MIN_DWELL <= 255)) begin : g_bad_params
    $error("thermo_power_ctrl: inconsistent threshold parameters");
  end
  logic [1:0] state_q, state_d, nxt, heat_lvl_q, heat_lvl_d, cool_lvl_q, cool_lvl_d;
  logic       heater_q, cooler_q, alarm, busy, load, clr;
  assign alarm = t_valid && (T < A_LO || T > A_HI);
  always_comb begin
    nxt = state_q == S_IDLE ? (T < H_ON ? S_HEAT : T > C_ON ? S_COOL : S_IDLE) :
          state_q == S_HEAT ? (T > H_OFF ? S_IDLE : S_HEAT) :
          state_q == S_COOL ? (T < C_OFF ? S_IDLE : S_COOL) :
          (T >= H_ON && T <= C_ON) ? S_IDLE : S_ALARM;
    clr = !alarm && !en && state_q != S_ALARM;
    state_d = alarm ? S_ALARM :
              !en ? (state_q == S_ALARM ? S_ALARM : S_IDLE) :
              (t_valid && !busy) ? nxt : state_q;
    load = state_d != state_q;
    heat_lvl_d = state_d != S_HEAT ? 2'd0 : !t_valid ? heat_lvl_q :
                 T < H_L3 ? 2'd3 : T < H_L2 ? 2'd2 : 2'd1;
    cool_lvl_d = state_d != S_COOL ? 2'd0 : !t_valid ? cool_lvl_q :
                 T > C_L3 ? 2'd3 : T > C_L2 ? 2'd2 : 2'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
      heat_lvl_q <= 2'd0;
      cool_lvl_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      heater_q   <= state_d == S_HEAT;
      cooler_q   <= state_d == S_COOL;
      heat_lvl_q <= heat_lvl_d;
      cool_lvl_q <= cool_lvl_d;
    end
  end
  dwell_timer #(.N(MIN_DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .load(load),
    .clr (clr),
    .busy(busy)
  );
  assign state      = state_q;
  assign heater     = heater_q;
  assign cooler     = cooler_q;
  assign heat_lvl   = heat_lvl_q;
  assign cool_lvl   = cool_lvl_q;
  assign dwell_busy = busy;
endmodule

// File: tb/tb_thermo_power_ctrl.sv
// tb_thermo_power_ctrl: directed scenario tests with hand-computed expected outputs
module tb_thermo_power_ctrl;
  import thermo_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, t_valid = 1'b0;
  logic signed [7:0] T = '0;
  logic heater, cooler, dwell_busy;
  logic [1:0] heat_lvl, cool_lvl, state;
  logic [8:0] obs, exp_v;
  int checks = 0, errors = 0;
  thermo_power_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .t_valid(t_valid), .T(T),
    .heater(heater), .cooler(cooler), .heat_lvl(heat_lvl), .cool_lvl(cool_lvl),
    .state(state), .dwell_busy(dwell_busy)
  );
  always #5 clk = ~clk;
  assign obs = {state, heater, cooler, heat_lvl, cool_lvl, dwell_busy};
  function automatic logic [8:0] pk(input logic [1:0] s, input logic h, input logic c,
                                    input logic [1:0] hl, input logic [1:0] cl, input logic b);
    return {s, h, c, hl, cl, b};
  endfunction
  task automatic step(input logic v, input int t);
    t_valid = v;
    T = 8'(t);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    step(1'b0, 0);
    rst = 1'b0;
  endtask
  task automatic wait_dwell();
    for (int i = 0; i < 20 && dwell_busy; i++) step(1'b0, 0);
    checks++;
    if (dwell_busy !== 1'b0) begin errors++; $display("FAIL dwell_timeout got %b exp 0", dwell_busy); end
  endtask
  task automatic test_reset();
    do_reset();
    exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_init got %b exp %b", obs, exp_v); end
  endtask
  task automatic test_hysteresis();
    do_reset();
    step(1, 20); exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_20 got %b exp %b", obs, exp_v); end
    step(1, 15); step(1, 35); exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_edges got %b exp %b", obs, exp_v); end
    step(1, 14); exp_v = pk(S_HEAT, 1, 0, 1, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_14 got %b exp %b", obs, exp_v); end
    step(1, 28); exp_v = pk(S_HEAT, 1, 0, 1, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_28 got %b exp %b", obs, exp_v); end
    wait_dwell();
    step(1, 30); exp_v = pk(S_HEAT, 1, 0, 1, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_30 got %b exp %b", obs, exp_v); end
    step(1, 31); exp_v = pk(S_IDLE, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hyst_31 got %b exp %b", obs, exp_v); end
  endtask
  task automatic test_levels();
    do_reset();
    step(1, 4); exp_v = pk(S_HEAT, 1, 0, 3, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL lvl_4 got %b exp %b", obs, exp_v); end
    step(1, 8); exp_v = pk(S_HEAT, 1, 0, 2, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL lvl_8 got %b exp %b", obs, exp_v); end
    step(1, 12); exp_v = pk(S_HEAT, 1, 0, 1, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL lvl_12 got %b exp %b", obs, exp_v); end
    step(0, -50); exp_v = pk(S_HEAT, 1, 0, 1, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL lvl_hold got %b exp %b", obs, exp_v); end
  endtask
  task automatic test_dwell();
    do_reset();
    step(1, 36); exp_v = pk(S_COOL, 0, 1, 0, 1, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL dwell_enter got %b exp %b", obs, exp_v); end
    for (int i = 0; i < 7; i++) begin
      step(1, 20); exp_v = pk(S_COOL, 0, 1, 0, 1, 1);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL dwell_hold%0d got %b exp %b", i, obs, exp_v); end
    end
    step(1, 20); exp_v = pk(S_COOL, 0, 1, 0, 1, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL dwell_fall got %b exp %b", obs, exp_v); end
    step(1, 20); exp_v = pk(S_IDLE, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL dwell_exit got %b exp %b", obs, exp_v); end
  endtask
  task automatic test_alarm();
    do_reset();
    step(1, 10); exp_v = pk(S_HEAT, 1, 0, 1, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_heat got %b exp %b", obs, exp_v); end
    step(1, -11); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_enter got %b exp %b", obs, exp_v); end
    step(1, 40); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_40 got %b exp %b", obs, exp_v); end
    step(1, 20); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_dwell got %b exp %b", obs, exp_v); end
    wait_dwell();
    step(1, 20); exp_v = pk(S_IDLE, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_exit got %b exp %b", obs, exp_v); end
    wait_dwell();
    step(1, -10); exp_v = pk(S_HEAT, 1, 0, 3, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_lo_edge got %b exp %b", obs, exp_v); end
    step(1, 61); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alm_61 got %b exp %b", obs, exp_v); end
  endtask
  task automatic test_enable();
    do_reset();
    step(1, 60); exp_v = pk(S_COOL, 0, 1, 0, 3, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL en_cool60 got %b exp %b", obs, exp_v); end
    step(1, 41); exp_v = pk(S_COOL, 0, 1, 0, 2, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL en_cool41 got %b exp %b", obs, exp_v); end
    en = 1'b0;
    step(0, 0); exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL en_off got %b exp %b", obs, exp_v); end
    step(1, 70); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL en_alarm got %b exp %b", obs, exp_v); end
    step(0, 0); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL en_alarm_hold got %b exp %b", obs, exp_v); end
    en = 1'b1;
  endtask
  task automatic test_reset_mid();
    do_reset();
    step(1, 36); step(1, 20); exp_v = pk(S_COOL, 0, 1, 0, 1, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rst_pre got %b exp %b", obs, exp_v); end
    rst = 1'b1;
    step(1, 70); exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rst_mid got %b exp %b", obs, exp_v); end
    rst = 1'b0;
    step(1, 70); exp_v = pk(S_ALARM, 0, 0, 0, 0, 1);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rst_pre_alarm got %b exp %b", obs, exp_v); end
    rst = 1'b1;
    step(1, 20); exp_v = pk(S_IDLE, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rst_alarm got %b exp %b", obs, exp_v); end
    rst = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_hysteresis();
    test_levels();
    test_dwell();
    test_alarm();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
